// File: rtl/msu_pkg.sv
// Shared sizing constants for the multiply/square unit blocks.
package msu_pkg;
    localparam int SqGridRows = 4;
    localparam int TreeBits   = 4;
    localparam int SqSumBits  = 8;
endpackage

// File: rtl/sq_split_terms_if.sv
// Handshake bundle for sq_split_terms: value input side and split-term output side.
interface sq_split_terms_if #(
    parameter int NumTerms = msu_pkg::SqGridRows,
    parameter int TermBits = msu_pkg::TreeBits,
    parameter int SumBits  = msu_pkg::SqSumBits
);
    logic [SumBits-1:0]  value_i;
    logic                valid_i;
    logic                ready_o;
    logic [TermBits-1:0] terms_o [NumTerms];
    logic                valid_o;
    logic                ready_i;
    logic                overflow_o;

    modport slave (
        input  value_i, valid_i, ready_i,
        output ready_o, terms_o, valid_o, overflow_o
    );

    modport master (
        output value_i, valid_i, ready_i,
        input  ready_o, terms_o, valid_o, overflow_o
    );
endinterface

// File: rtl/sq_split_terms.sv
// Splits a value into NumTerms saturating terms of at most 2^TermBits-1 each (inverse of the square-sum term adder).
// Optional macro SQ_SPLIT_TERMS_EARLY_DONE_EN: finish SPLIT as soon as the remainder reaches zero.
module sq_split_terms #(
    parameter int NumTerms = msu_pkg::SqGridRows,
    parameter int TermBits = msu_pkg::TreeBits,
    parameter int SumBits  = msu_pkg::SqSumBits
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sq_split_terms_if.slave bus
);
    localparam int IdxBits = (NumTerms > 1) ? $clog2(NumTerms) : 1;
    localparam logic [SumBits-1:0] TermMax = SumBits'((64'd1 << TermBits) - 64'd1);
    localparam logic [IdxBits-1:0] LastIdx = IdxBits'(NumTerms - 1);

    typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

    state_t              state_reg;
    logic [SumBits-1:0]  rem_reg;
    logic [IdxBits-1:0]  idx_reg;
    logic [TermBits-1:0] terms_reg [NumTerms];
    logic                ready_reg;
    logic                valid_reg;
    logic                overflow_reg;

    logic [SumBits-1:0]  take_next;
    logic [SumBits-1:0]  rem_next;
    logic                split_end;

    // The min is taken at full remainder width so large remainders saturate rather than wrap.
    always_comb begin
        take_next = (rem_reg > TermMax) ? TermMax : rem_reg;
        rem_next  = rem_reg - take_next;
`ifdef SQ_SPLIT_TERMS_EARLY_DONE_EN
        split_end = (idx_reg == LastIdx) || (rem_next == '0);
`else
        split_end = (idx_reg == LastIdx);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            rem_reg      <= '0;
            idx_reg      <= '0;
            ready_reg    <= 1'b1;
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < NumTerms; i++) begin
                terms_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid_i) begin
                        rem_reg      <= bus.value_i;
                        idx_reg      <= '0;
                        overflow_reg <= 1'b0;
                        for (int i = 0; i < NumTerms; i++) begin
                            terms_reg[i] <= '0;
                        end
                        ready_reg    <= 1'b0;
                        state_reg    <= SPLIT;
                    end
                end
                SPLIT: begin
                    terms_reg[idx_reg] <= take_next[TermBits-1:0];
                    rem_reg            <= rem_next;
                    idx_reg            <= idx_reg + 1'b1;
                    if (split_end) begin
                        // Any remainder left after the last term is the overflow.
                        overflow_reg <= (rem_next != '0);
                        valid_reg    <= 1'b1;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NumTerms; gi++) begin : g_terms
            assign bus.terms_o[gi] = terms_reg[gi];
        end
    endgenerate

    assign bus.ready_o    = ready_reg;
    assign bus.valid_o    = valid_reg;
    assign bus.overflow_o = overflow_reg;
endmodule

// File: tb/tb_sq_split_terms.sv
// Directed and randomized checks of sq_split_terms with NumTerms=4, TermBits=4, SumBits=8.
module tb_sq_split_terms;
    localparam int NumTerms = 4;
    localparam int TermBits = 4;
    localparam int SumBits  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_compared   = 0;
    int   n_mismatched = 0;

    sq_split_terms_if #(.NumTerms(NumTerms), .TermBits(TermBits), .SumBits(SumBits)) bus();

    sq_split_terms #(.NumTerms(NumTerms), .TermBits(TermBits), .SumBits(SumBits)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_value(input string tag, input int got, input int exp);
        n_compared++;
        if (got != exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_latency(input int v);
        int n;
        n = NumTerms;
`ifdef SQ_SPLIT_TERMS_EARLY_DONE_EN
        n = (v + 14) / 15;
        if (n < 1) n = 1;
        if (n > NumTerms) n = NumTerms;
`endif
        return n;
    endfunction

    // Called at a falling edge in IDLE; returns at the falling edge after the accept edge.
    task automatic accept(input string tag, input int v);
        check_value({tag, " ready_idle"}, int'(bus.ready_o), 1);
        bus.value_i = 8'(v);
        bus.valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.value_i = 8'hA5;
        $display("accept %s value=%0d", tag, v);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_terms(input string tag, input logic [15:0] exp, input int exp_ovf);
        for (int i = 0; i < NumTerms; i++) begin
            check_value($sformatf("%s term%0d", tag, i), int'(bus.terms_o[i]), int'(exp[15-4*i -: 4]));
        end
        check_value({tag, " overflow"}, int'(bus.overflow_o), exp_ovf);
    endtask

    task automatic consume(input string tag);
        bus.ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready_i = 1'b0;
        check_value({tag, " valid_after_consume"}, int'(bus.valid_o), 0);
    endtask

    task automatic run_vector(input string tag, input int v, input logic [15:0] exp, input int exp_ovf);
        int lat;
        accept(tag, v);
        wait_valid(lat);
        check_value({tag, " latency"}, lat, exp_latency(v));
        check_terms(tag, exp, exp_ovf);
        $display("result %s value=%0d terms=%0d,%0d,%0d,%0d ovf=%0d lat=%0d", tag, v,
                 bus.terms_o[0], bus.terms_o[1], bus.terms_o[2], bus.terms_o[3], bus.overflow_o, lat);
        consume(tag);
    endtask

    initial begin
        int lat;
        int any_valid;
        int v;
        int sum;
        int stall;

        bus.value_i = '0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_value("reset ready", int'(bus.ready_o), 1);
        check_value("reset valid", int'(bus.valid_o), 0);
        check_terms("reset", 16'h0000, 0);
        rst = 1'b0;
        @(negedge clk);

        run_vector("v37",  37,  16'hFF70, 0);
        run_vector("v60",  60,  16'hFFFF, 0);
        run_vector("v61",  61,  16'hFFFF, 1);
        run_vector("v0",   0,   16'h0000, 0);
        run_vector("v16",  16,  16'hF100, 0);
        run_vector("v255", 255, 16'hFFFF, 1);

        // Hold off the consumer while DONE; outputs must not move.
        accept("stall20", 20);
        wait_valid(lat);
        check_value("stall20 latency", lat, exp_latency(20));
        for (int k = 0; k < 5; k++) begin
            check_terms($sformatf("stall20 c%0d", k), 16'hF500, 0);
            check_value($sformatf("stall20 c%0d ready", k), int'(bus.ready_o), 0);
            check_value($sformatf("stall20 c%0d valid", k), int'(bus.valid_o), 1);
            @(negedge clk);
        end
        consume("stall20");
        run_vector("v9", 9, 16'h9000, 0);

        // Reset during the second SPLIT cycle drops the value.
        accept("rst45", 45);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_value("rst45 valid", int'(bus.valid_o), 0);
        check_value("rst45 ready", int'(bus.ready_o), 1);
        check_terms("rst45", 16'h0000, 0);
        any_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.valid_o) any_valid = 1;
        end
        check_value("rst45 no_output", any_valid, 0);
        run_vector("v3", 3, 16'h3000, 0);

        for (int n = 0; n < 24; n++) begin
            v = int'($urandom_range(0, 255));
            accept($sformatf("rand%0d", n), v);
            bus.ready_i = 1'(($urandom_range(0, 1)));
            wait_valid(lat);
            bus.ready_i = 1'b0;
            check_value($sformatf("rand%0d valid", n), int'(bus.valid_o), 1);
            stall = int'($urandom_range(0, 3));
            repeat (stall) @(negedge clk);
            sum = 0;
            for (int i = 0; i < NumTerms; i++) sum += int'(bus.terms_o[i]);
            check_value($sformatf("rand%0d overflow", n), int'(bus.overflow_o), (v > 60) ? 1 : 0);
            if (v <= 60) check_value($sformatf("rand%0d sum", n), sum, v);
            $display("rand%0d value=%0d sum=%0d ovf=%0d", n, v, sum, bus.overflow_o);
            consume($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/sq_split_terms.md
SQ_SPLIT_TERMS -- requirements
Module: sq_split_terms

Interface
REQ-001 SHALL have parameter NumTerms, default msu_pkg::SqGridRows: number of output terms.
REQ-002 SHALL have parameter TermBits, default msu_pkg::TreeBits: width of each term.
REQ-003 SHALL have parameter SumBits, default msu_pkg::SqSumBits: width of the input value.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; no other clock or reset.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: synchronous reset, active-high.
REQ-007 SHALL have port value_i, input, SumBits: value to split.
REQ-008 SHALL have port valid_i, input, 1: value_i is valid.
REQ-009 SHALL have port ready_o, output, 1: block accepts value_i.
REQ-010 SHALL have port terms_o[NumTerms], output, TermBits each: split terms.
REQ-011 SHALL have port valid_o, output, 1: terms_o and overflow_o are valid.
REQ-012 SHALL have port ready_i, input, 1: downstream consumes terms_o.
REQ-013 SHALL have port overflow_o, output, 1: value exceeded NumTerms*TermMax.

Function
REQ-014 SHALL define TermMax = 2^TermBits - 1.
- Unweighted sum of terms_o SHALL equal value_i whenever overflow_o = 0.
- This makes the block the inverse of the square-sum term adder.
REQ-015 SHALL implement the FSM states IDLE, SPLIT and DONE.
- ready_o = 1 only in IDLE.
- valid_o = 1 only in DONE.
REQ-016 IDLE SHALL accept when valid_i && ready_o, with these actions:
- load rem = value_i and idx = 0.
- clear all terms_o to 0 and overflow_o to 0.
- go to SPLIT.
REQ-017 Each SPLIT cycle SHALL perform, at the rising edge:
- write terms_o[idx] = min(rem, TermMax).
- set rem = rem - terms_o[idx].
- increment idx.
REQ-018 SPLIT SHALL go to DONE at the edge that writes idx = NumTerms-1.
- At that edge, overflow_o = 1 iff the updated rem != 0.
REQ-019 Latency (base build): accept at edge t; valid_o = 1 in the cycle after edge t+NumTerms.
REQ-020 DONE SHALL hold terms_o and overflow_o stable while ready_i = 0.
- valid_o stays 1 until consumed.
REQ-021 DONE with ready_i = 1 SHALL go to IDLE at that edge, with no bubble restriction.
- A new value may be accepted in the next cycle.
REQ-022 terms_o SHALL change only during the accept edge and SPLIT edges; they hold otherwise.
REQ-023 valid_i SHALL be ignored outside IDLE, and value_i SHALL be sampled only at the accept edge.
REQ-024 Arithmetic:
- rem SHALL be SumBits wide and SHALL never underflow.
- The min comparison SHALL be performed at SumBits width.
- Parameters SHALL satisfy SumBits >= TermBits and NumTerms >= 1.
REQ-025 With NumTerms = 1, SPLIT SHALL last exactly one cycle.

Reset
REQ-026 rst_i = 1 SHALL force the following at the next edge, regardless of state, including mid-SPLIT or DONE:
- state IDLE.
- ready_o = 1 after reset release.
- valid_o = 0 and overflow_o = 0.
- all terms_o = 0, rem = 0, idx = 0.
REQ-027 An in-flight value SHALL be discarded on reset, with no output produced for it.

Configuration
REQ-028 Macro SQ_SPLIT_TERMS_EARLY_DONE_EN SHALL control early completion.
- When defined: a SPLIT edge whose updated rem = 0 SHALL go directly to DONE, leaving the remaining terms at 0 and overflow_o = 0.
- Latency becomes ceil(value/TermMax) SPLIT cycles, minimum 1.
- When undefined: SPLIT always lasts exactly NumTerms cycles per REQ-019.
- Terms and overflow results SHALL be identical in both builds.

Verification (NumTerms=4, TermBits=4, TermMax=15, SumBits=8)
REQ-029 value 37 -> terms {15,15,7,0}, overflow 0, valid_o 4 cycles after accept (base build).
REQ-030 Boundary values:
- value 60 -> terms {15,15,15,15}, overflow 0.
- value 61 -> terms {15,15,15,15}, overflow 1.
- value 0 -> all terms 0, overflow 0.
REQ-031 value 20, ready_i held 0 for 5 cycles after valid_o -> terms {15,5,0,0} stable, ready_o 0 throughout.
- Handshake on the 6th cycle.
- Next value 9 accepted the following cycle -> {9,0,0,0}.
REQ-032 value 45 accepted, rst_i pulsed on the 2nd SPLIT cycle -> no valid_o, all outputs 0.
- Subsequent value 3 -> {3,0,0,0}.
REQ-033 With SQ_SPLIT_TERMS_EARLY_DONE_EN defined:
- value 20 -> valid_o after 2 SPLIT cycles, terms {15,5,0,0}.
- value 0 -> valid_o after 1 SPLIT cycle.
REQ-034 Random values 0..255, random ready_i -> sum of terms_o equals value when overflow_o = 0, and overflow_o equals (value > 60).
